// File: rtl/laser_pkg.sv
// Shared constants, coordinate type and FSM state encoding for the laser_score checker.
package laser_pkg;

   localparam int NPTS_DEF = 40;
   localparam int CW_DEF   = 4;
   localparam int R2       = 16;

   typedef logic [CW_DEF-1:0] coord_t;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd1,
      EVAL    = 2'd2,
      REPORT  = 2'd3
   } state_t;

endpackage

// File: rtl/laser_cover.sv
// Combinational coverage test: is (px,py) within radius sqrt(R2) of centre (cx,cy)?
module laser_cover
   import laser_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic [CW-1:0] px_i,
   input  logic [CW-1:0] py_i,
   input  logic [CW-1:0] cx_i,
   input  logic [CW-1:0] cy_i,
   output logic          covered_o
);

   logic [CW-1:0] dx;
   logic [CW-1:0] dy;
   logic [2*CW:0] dx_w;
   logic [2*CW:0] dy_w;
   logic [2*CW:0] dist2;

   assign dx = (px_i >= cx_i) ? (px_i - cx_i) : (cx_i - px_i);
   assign dy = (py_i >= cy_i) ? (py_i - cy_i) : (cy_i - py_i);

   // Widened before squaring so the sum of squares never wraps.
   assign dx_w  = {{(CW+1){1'b0}}, dx};
   assign dy_w  = {{(CW+1){1'b0}}, dy};
   assign dist2 = dx_w * dx_w + dy_w * dy_w;

   assign covered_o = (dist2 <= (2*CW+1)'(R2));

endmodule

// File: rtl/laser_score.sv
// Re-scores the two-circle engine's answer over the snooped frame.
// Optional OVERLAP output enabled by defining LASER_SCORE_OVERLAP_EN.
module laser_score
   import laser_pkg::*;
#(
   parameter int NPTS = NPTS_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          PT_VALID,
   input  logic [CW-1:0] PT_X,
   input  logic [CW-1:0] PT_Y,
   input  logic          RES_VALID,
   input  logic [CW-1:0] C1X,
   input  logic [CW-1:0] C1Y,
   input  logic [CW-1:0] C2X,
   input  logic [CW-1:0] C2Y,
   output logic          BUSY,
   output logic [5:0]    SCORE,
   output logic          SCORE_VALID,
`ifdef LASER_SCORE_OVERLAP_EN
   output logic [5:0]    OVERLAP,
`endif
   output logic          ERR
);

   localparam logic [5:0] LAST = 6'(NPTS - 1);

   state_t        state_q, state_d;
   logic [5:0]    pcnt_q, pcnt_d;
   logic [5:0]    idx_q, idx_d;
   logic [5:0]    acc_q, acc_d;
   logic [5:0]    score_q, score_d;
   logic          err_q, err_d;
   logic [CW-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
   logic          shift_in, rotate;
   logic          cov1, cov2;
   logic [CW-1:0] sx_q [NPTS];
   logic [CW-1:0] sy_q [NPTS];
`ifdef LASER_SCORE_OVERLAP_EN
   logic [5:0]    ovl_acc_q, ovl_acc_d;
   logic [5:0]    ovl_q, ovl_d;
`endif

   laser_cover #(.CW(CW)) u_cover1 (
      .px_i(sx_q[0]), .py_i(sy_q[0]), .cx_i(c1x_q), .cy_i(c1y_q), .covered_o(cov1)
   );
   laser_cover #(.CW(CW)) u_cover2 (
      .px_i(sx_q[0]), .py_i(sy_q[0]), .cx_i(c2x_q), .cy_i(c2y_q), .covered_o(cov2)
   );

   // Store contents are don't-care while pcnt is zero, so it carries no reset.
   always_ff @(posedge CLK) begin
      if (shift_in || rotate) begin
         for (int i = 0; i < NPTS - 1; i++) begin
            sx_q[i] <= sx_q[i+1];
            sy_q[i] <= sy_q[i+1];
         end
         sx_q[NPTS-1] <= shift_in ? PT_X : sx_q[0];
         sy_q[NPTS-1] <= shift_in ? PT_Y : sy_q[0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= COLLECT;
         pcnt_q  <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         score_q <= '0;
         err_q   <= 1'b0;
         c1x_q   <= '0;
         c1y_q   <= '0;
         c2x_q   <= '0;
         c2y_q   <= '0;
`ifdef LASER_SCORE_OVERLAP_EN
         ovl_acc_q <= '0;
         ovl_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         score_q <= score_d;
         err_q   <= err_d;
         c1x_q   <= c1x_d;
         c1y_q   <= c1y_d;
         c2x_q   <= c2x_d;
         c2y_q   <= c2y_d;
`ifdef LASER_SCORE_OVERLAP_EN
         ovl_acc_q <= ovl_acc_d;
         ovl_q     <= ovl_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      score_d  = score_q;
      err_d    = err_q;
      c1x_d    = c1x_q;
      c1y_d    = c1y_q;
      c2x_d    = c2x_q;
      c2y_d    = c2y_q;
      shift_in = 1'b0;
      rotate   = 1'b0;
`ifdef LASER_SCORE_OVERLAP_EN
      ovl_acc_d = ovl_acc_q;
      ovl_d     = ovl_q;
`endif
      case (state_q)
         COLLECT: begin
            // A result before the frame is complete wins over a same-cycle point.
            if (RES_VALID) begin
               err_d  = 1'b1;
               pcnt_d = '0;
            end else if (PT_VALID) begin
               shift_in = 1'b1;
               pcnt_d   = pcnt_q + 6'd1;
               if (pcnt_q == LAST) state_d = HOLD;
            end
         end
         HOLD: begin
            if (PT_VALID) err_d = 1'b1;
            if (RES_VALID) begin
               c1x_d   = C1X;
               c1y_d   = C1Y;
               c2x_d   = C2X;
               c2y_d   = C2Y;
               acc_d   = '0;
               idx_d   = '0;
               state_d = EVAL;
`ifdef LASER_SCORE_OVERLAP_EN
               ovl_acc_d = '0;
`endif
            end
         end
         EVAL: begin
            rotate = 1'b1;
            acc_d  = acc_q + {5'd0, cov1 | cov2};
            idx_d  = idx_q + 6'd1;
            if (PT_VALID || RES_VALID) err_d = 1'b1;
`ifdef LASER_SCORE_OVERLAP_EN
            ovl_acc_d = ovl_acc_q + {5'd0, cov1 & cov2};
`endif
            if (idx_q == LAST) begin
               state_d = REPORT;
               score_d = acc_d;
`ifdef LASER_SCORE_OVERLAP_EN
               ovl_d = ovl_acc_d;
`endif
            end
         end
         REPORT: begin
            pcnt_d  = '0;
            state_d = COLLECT;
            if (PT_VALID) begin
               shift_in = 1'b1;
               pcnt_d   = 6'd1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   assign BUSY        = (state_q == HOLD) || (state_q == EVAL);
   assign SCORE_VALID = (state_q == REPORT);
   assign SCORE       = score_q;
   assign ERR         = err_q;
`ifdef LASER_SCORE_OVERLAP_EN
   assign OVERLAP     = ovl_q;
`endif

endmodule

// File: tb/tb_laser_score.sv
// Scoreboard testbench for laser_score; expected scores come from an integer reference model.
module tb_laser_score;

   localparam int NPTS = 40;
   localparam int CW   = 4;

   typedef struct packed {
      logic [5:0] score;
      logic [5:0] ovl;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          PT_VALID = 1'b0;
   logic [CW-1:0] PT_X = '0;
   logic [CW-1:0] PT_Y = '0;
   logic          RES_VALID = 1'b0;
   logic [CW-1:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
   logic          BUSY, SCORE_VALID, ERR;
   logic [5:0]    SCORE;
`ifdef LASER_SCORE_OVERLAP_EN
   logic [5:0]    OVERLAP;
`endif

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   px[NPTS];
   int   py[NPTS];

   laser_score #(.NPTS(NPTS), .CW(CW)) dut (
      .CLK(CLK), .RST(RST),
      .PT_VALID(PT_VALID), .PT_X(PT_X), .PT_Y(PT_Y),
      .RES_VALID(RES_VALID), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
      .BUSY(BUSY), .SCORE(SCORE), .SCORE_VALID(SCORE_VALID),
`ifdef LASER_SCORE_OVERLAP_EN
      .OVERLAP(OVERLAP),
`endif
      .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic bit covers(int x, int y, int cx, int cy);
      int dx = x - cx;
      int dy = y - cy;
      return (dx * dx + dy * dy) <= 16;
   endfunction

   function automatic exp_t model(int ax, int ay, int bx, int by);
      int   s = 0;
      int   o = 0;
      exp_t r;
      for (int i = 0; i < NPTS; i++) begin
         bit k1 = covers(px[i], py[i], ax, ay);
         bit k2 = covers(px[i], py[i], bx, by);
         if (k1 || k2) s++;
         if (k1 && k2) o++;
      end
      r.score = 6'(s);
      r.ovl   = 6'(o);
      return r;
   endfunction

   task automatic do_reset();
      RST = 1'b1; PT_VALID = 1'b0; RES_VALID = 1'b0;
      step(); step();
      RST = 1'b0;
   endtask

   task automatic rand_frame();
      for (int i = 0; i < NPTS; i++) begin
         px[i] = int'($urandom_range(0, 15));
         py[i] = int'($urandom_range(0, 15));
      end
   endtask

   task automatic drive_pts(int first, int n);
      for (int i = first; i < first + n; i++) begin
         PT_VALID = 1'b1;
         PT_X = CW'(px[i]);
         PT_Y = CW'(py[i]);
         step();
      end
      PT_VALID = 1'b0;
   endtask

   task automatic send_result(int ax, int ay, int bx, int by, bit push);
      RES_VALID = 1'b1;
      C1X = CW'(ax); C1Y = CW'(ay); C2X = CW'(bx); C2Y = CW'(by);
      if (push) exp_q.push_back(model(ax, ay, bx, by));
      step();
      RES_VALID = 1'b0;
   endtask

   // lat counts cycles since the RES_VALID cycle.
   task automatic wait_score(int budget, output bit got, output int lat);
      got = 1'b0;
      lat = 1;
      while (lat <= budget && !got) begin
         if (SCORE_VALID) got = 1'b1;
         else begin
            step();
            lat++;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", BUSY); end
      checks++; if (SCORE !== 6'd0) begin errors++; $display("FAIL reset_score: got %0d required 0", SCORE); end
      checks++; if (SCORE_VALID !== 1'b0) begin errors++; $display("FAIL reset_svalid: got %b required 0", SCORE_VALID); end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", ERR); end
`ifdef LASER_SCORE_OVERLAP_EN
      checks++; if (OVERLAP !== 6'd0) begin errors++; $display("FAIL reset_ovl: got %0d required 0", OVERLAP); end
`endif
   endtask

   task automatic test_all_same();
      bit   got;
      int   lat;
      exp_t e;
      do_reset();
      for (int i = 0; i < NPTS; i++) begin px[i] = 8; py[i] = 8; end
      drive_pts(0, NPTS - 1);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL same_busy_early: got %b required 0", BUSY); end
      drive_pts(NPTS - 1, 1);
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL same_busy_rise: got %b required 1", BUSY); end
      repeat (4) step();
      send_result(8, 8, 0, 0, 1'b1);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL same_valid: SCORE_VALID 0 after %0d cycles, required 1", lat - 1); end
      else begin
         e = exp_q.pop_front();
         $display("frame same: SCORE=%0d expected=%0d latency=%0d", SCORE, e.score, lat);
         checks++; if (lat !== 41) begin errors++; $display("FAIL same_latency: got %0d required 41", lat); end
         checks++; if (SCORE !== 6'd40) begin errors++; $display("FAIL same_score: got %0d required 40", SCORE); end
         checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL same_busy_report: got %b required 0", BUSY); end
`ifdef LASER_SCORE_OVERLAP_EN
         checks++; if (OVERLAP !== e.ovl) begin errors++; $display("FAIL same_ovl: got %0d required %0d", OVERLAP, e.ovl); end
`endif
      end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL same_err: got %b required 0", ERR); end
      step();
      checks++; if (SCORE_VALID !== 1'b0) begin errors++; $display("FAIL same_pulse: got %b required 0", SCORE_VALID); end
      checks++; if (SCORE !== 6'd40) begin errors++; $display("FAIL same_hold: got %0d required 40", SCORE); end
   endtask

   task automatic test_edges();
      bit   got;
      int   lat;
      exp_t e;
      do_reset();
      for (int i = 0; i < NPTS; i++) begin
         px[i] = ((i % 32) < 16) ? 0 : 15;
         py[i] = i % 16;
      end
      drive_pts(0, NPTS);
      send_result(0, 4, 15, 11, 1'b1);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL edges_valid: SCORE_VALID 0, required 1"); end
      else begin
         e = exp_q.pop_front();
         $display("frame edges: SCORE=%0d expected=%0d", SCORE, e.score);
         checks++; if (SCORE !== e.score) begin errors++; $display("FAIL edges_score: got %0d required %0d", SCORE, e.score); end
`ifdef LASER_SCORE_OVERLAP_EN
         checks++; if (OVERLAP !== 6'd0) begin errors++; $display("FAIL edges_ovl: got %0d required 0", OVERLAP); end
`endif
      end
   endtask

   task automatic test_boundary();
      bit   got;
      int   lat;
      exp_t e;
      int   bx[6] = '{11, 10, 12, 11, 13, 12};
      int   by[6] = '{10, 11, 8, 11, 8, 9};
      do_reset();
      for (int i = 0; i < NPTS; i++) begin
         px[i] = (i < 6) ? bx[i] : 0;
         py[i] = (i < 6) ? by[i] : 15;
      end
      drive_pts(0, NPTS);
      // A stray point while holding is flagged but must not disturb the frame.
      PT_VALID = 1'b1; PT_X = 4'd8; PT_Y = 4'd8;
      step();
      PT_VALID = 1'b0;
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL bound_hold_err: got %b required 1", ERR); end
      exp_q.push_back(exp_t'{6'd3, 6'd0});
      send_result(8, 8, 15, 0, 1'b0);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL bound_valid: SCORE_VALID 0, required 1"); end
      else begin
         e = exp_q.pop_front();
         $display("frame boundary: SCORE=%0d expected=%0d", SCORE, e.score);
         checks++; if (SCORE !== e.score) begin errors++; $display("FAIL bound_score: got %0d required %0d", SCORE, e.score); end
`ifdef LASER_SCORE_OVERLAP_EN
         checks++; if (OVERLAP !== e.ovl) begin errors++; $display("FAIL bound_ovl: got %0d required %0d", OVERLAP, e.ovl); end
`endif
      end
   endtask

   task automatic test_short_frame();
      bit   got;
      int   lat;
      exp_t e;
      do_reset();
      rand_frame();
      drive_pts(0, 20);
      send_result(3, 3, 12, 12, 1'b0);
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL short_err: got %b required 1", ERR); end
      wait_score(60, got, lat);
      checks++; if (got !== 1'b0) begin errors++; $display("FAIL short_novalid: SCORE_VALID 1, required 0"); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL short_busy: got %b required 0", BUSY); end
      rand_frame();
      drive_pts(0, NPTS);
      send_result(5, 6, 10, 9, 1'b1);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL short_next_valid: SCORE_VALID 0, required 1"); end
      else begin
         e = exp_q.pop_front();
         $display("frame after short: SCORE=%0d expected=%0d", SCORE, e.score);
         checks++; if (SCORE !== e.score) begin errors++; $display("FAIL short_next_score: got %0d required %0d", SCORE, e.score); end
`ifdef LASER_SCORE_OVERLAP_EN
         checks++; if (OVERLAP !== e.ovl) begin errors++; $display("FAIL short_next_ovl: got %0d required %0d", OVERLAP, e.ovl); end
`endif
      end
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL short_sticky: got %b required 1", ERR); end
   endtask

   task automatic test_back_to_back();
      bit   got;
      int   lat;
      exp_t e;
      do_reset();
      rand_frame();
      drive_pts(0, NPTS);
      send_result(4, 4, 11, 11, 1'b1);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL b2b_valid1: SCORE_VALID 0, required 1"); end
      else begin
         e = exp_q.pop_front();
         $display("frame b2b #1: SCORE=%0d expected=%0d", SCORE, e.score);
         checks++; if (SCORE !== e.score) begin errors++; $display("FAIL b2b_score1: got %0d required %0d", SCORE, e.score); end
      end
      // First point of frame 2 goes out in this (REPORT) cycle.
      rand_frame();
      drive_pts(0, NPTS - 1);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy39: got %b required 0", BUSY); end
      drive_pts(NPTS - 1, 1);
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_busy40: got %b required 1", BUSY); end
      send_result(7, 2, 9, 13, 1'b1);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL b2b_valid2: SCORE_VALID 0, required 1"); end
      else begin
         e = exp_q.pop_front();
         $display("frame b2b #2: SCORE=%0d expected=%0d", SCORE, e.score);
         checks++; if (SCORE !== e.score) begin errors++; $display("FAIL b2b_score2: got %0d required %0d", SCORE, e.score); end
`ifdef LASER_SCORE_OVERLAP_EN
         checks++; if (OVERLAP !== e.ovl) begin errors++; $display("FAIL b2b_ovl2: got %0d required %0d", OVERLAP, e.ovl); end
`endif
      end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b required 0", ERR); end
   endtask

   task automatic test_rst_mid_eval();
      bit   got;
      int   lat;
      exp_t e;
      do_reset();
      for (int i = 0; i < NPTS; i++) begin px[i] = 8; py[i] = 8; end
      drive_pts(0, NPTS);
      send_result(8, 8, 0, 0, 1'b1);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL rst_pre_valid: SCORE_VALID 0, required 1"); end
      else begin
         e = exp_q.pop_front();
         $display("frame before rst: SCORE=%0d expected=%0d", SCORE, e.score);
         checks++; if (SCORE !== e.score) begin errors++; $display("FAIL rst_pre_score: got %0d required %0d", SCORE, e.score); end
      end
      rand_frame();
      drive_pts(0, NPTS);
      send_result(1, 1, 14, 14, 1'b0);
      repeat (10) step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", BUSY); end
      checks++; if (SCORE !== 6'd0) begin errors++; $display("FAIL rst_score: got %0d required 0", SCORE); end
      checks++; if (SCORE_VALID !== 1'b0) begin errors++; $display("FAIL rst_svalid: got %b required 0", SCORE_VALID); end
      rand_frame();
      drive_pts(0, NPTS);
      send_result(6, 9, 9, 6, 1'b1);
      wait_score(60, got, lat);
      checks++;
      if (!got) begin errors++; $display("FAIL rst_post_valid: SCORE_VALID 0, required 1"); end
      else begin
         e = exp_q.pop_front();
         $display("frame after rst: SCORE=%0d expected=%0d", SCORE, e.score);
         checks++; if (SCORE !== e.score) begin errors++; $display("FAIL rst_post_score: got %0d required %0d", SCORE, e.score); end
`ifdef LASER_SCORE_OVERLAP_EN
         checks++; if (OVERLAP !== e.ovl) begin errors++; $display("FAIL rst_post_ovl: got %0d required %0d", OVERLAP, e.ovl); end
`endif
      end
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_post_err: got %b required 0", ERR); end
   endtask

   initial begin
      test_reset();
      test_all_same();
      test_edges();
      test_boundary();
      test_short_frame();
      test_back_to_back();
      test_rst_mid_eval();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d results outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at 200000 time units, required completion");
      $fatal(1, "timeout");
   end

endmodule
